// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions: handshake FSM states and a saturating
// increment helper used by stage counters.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pipe_state_e;

    localparam int unsigned SAT_W = 64;

    // Counters up to SAT_W bits share this; width selects the ceiling.
    function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] value,
                                                 input int unsigned       width);
        logic [SAT_W-1:0] max_val;
        max_val = {SAT_W{1'b1}} >> (SAT_W - width);
        return (value >= max_val) ? value : value + SAT_W'(1);
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline holding slot: valid flag plus control and payload registers,
// with synchronous reset, valid-only clear and load enable.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int unsigned CTRL_W = 8,
    parameter int unsigned DATA_W = 128
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              load_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o
);

    // Clear drops only the valid bit; payload stays stale until next load.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o <= 1'b0;
            ctrl_o  <= '0;
            data_o  <= '0;
        end else if (clr_i) begin
            valid_o <= 1'b0;
        end else if (load_i) begin
            valid_o <= 1'b1;
            ctrl_o  <= ctrl_i;
            data_o  <= data_i;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage with a 2-entry skid buffer, flush, bubble
// control masking and a saturating stall-cycle counter.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int unsigned CTRL_W              = 8,
    parameter int unsigned DATA_W              = 128,
    parameter bit          ZERO_CTRL_ON_BUBBLE = 1'b1,
    parameter int unsigned CNT_W               = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              flush_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    pipe_state_e       state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic              in_fire, out_fire;
    logic              main_load, main_clr, skid_load, skid_clr;
    logic [CTRL_W-1:0] main_ctrl_d, main_ctrl, skid_ctrl;
    logic [DATA_W-1:0] main_data_d, main_data, skid_data;
    logic              main_valid, skid_valid;
    logic [CNT_W-1:0]  stall_cnt_q;

    assign in_fire  = in_valid_i & in_ready_q;
    assign out_fire = main_valid & out_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        main_load   = 1'b0;
        main_clr    = 1'b0;
        skid_load   = 1'b0;
        skid_clr    = 1'b0;
        main_ctrl_d = in_ctrl_i;
        main_data_d = in_data_i;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    main_load = 1'b1;
                    state_d   = ONE;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_load = 1'b1;
                end else if (in_fire) begin
                    skid_load = 1'b1;
                    state_d   = FULL;
                end else if (out_fire) begin
                    main_clr  = 1'b1;
                    state_d   = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    main_load   = 1'b1;
                    main_ctrl_d = skid_ctrl;
                    main_data_d = skid_data;
                    skid_clr    = 1'b1;
                    state_d     = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush_i) begin
            main_load = 1'b0;
            skid_load = 1'b0;
            main_clr  = 1'b1;
            skid_clr  = 1'b1;
            state_d   = EMPTY;
        end
        in_ready_d = (state_d != FULL);
    end

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (main_clr),
        .load_i  (main_load),
        .ctrl_i  (main_ctrl_d),
        .data_i  (main_data_d),
        .valid_o (main_valid),
        .ctrl_o  (main_ctrl),
        .data_o  (main_data)
    );

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (skid_clr),
        .load_i  (skid_load),
        .ctrl_i  (in_ctrl_i),
        .data_i  (in_data_i),
        .valid_o (skid_valid),
        .ctrl_o  (skid_ctrl),
        .data_o  (skid_data)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else if (main_valid && !out_ready_i) begin
            stall_cnt_q <= CNT_W'(sat_inc(SAT_W'(stall_cnt_q), CNT_W));
        end
    end

    // The ready register mirrors the inverted skid valid at all times.
    a_ready_mirrors_skid: assert property (@(posedge clk_i) disable iff (rst_i)
        in_ready_q == !skid_valid);

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = main_valid;
    assign out_data_o  = main_data;
    assign out_ctrl_o  = (ZERO_CTRL_ON_BUBBLE && !main_valid) ? '0 : main_ctrl;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Randomised and directed check of pipe_stage_skid against a queue-based model;
// three instances cover default, narrow-counter and unmasked-ctrl variants.
module tb_pipe_stage_skid;

    typedef struct {
        logic [7:0]   c;
        logic [127:0] d;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst, iv, ordy, flush;
    logic [7:0]   ictrl;
    logic [127:0] idata;

    logic         a_ir, a_ov, b_ir, b_ov, c_ir, c_ov;
    logic [7:0]   a_oc, b_oc, c_oc;
    logic [127:0] a_od, b_od, c_od;
    logic [15:0]  a_cnt, c_cnt;
    logic [3:0]   b_cnt;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    beat_t  q[$];
    beat_t  shown;
    longint cnt;
    bit     m_ov, m_ir;

    always #5 clk = ~clk;

    pipe_stage_skid dut_a (
        .clk_i(clk), .rst_i(rst), .in_valid_i(iv), .in_ready_o(a_ir),
        .in_ctrl_i(ictrl), .in_data_i(idata), .flush_i(flush),
        .out_valid_o(a_ov), .out_ready_i(ordy), .out_ctrl_o(a_oc),
        .out_data_o(a_od), .stall_cnt_o(a_cnt)
    );

    pipe_stage_skid #(.CNT_W(4)) dut_b (
        .clk_i(clk), .rst_i(rst), .in_valid_i(iv), .in_ready_o(b_ir),
        .in_ctrl_i(ictrl), .in_data_i(idata), .flush_i(flush),
        .out_valid_o(b_ov), .out_ready_i(ordy), .out_ctrl_o(b_oc),
        .out_data_o(b_od), .stall_cnt_o(b_cnt)
    );

    pipe_stage_skid #(.ZERO_CTRL_ON_BUBBLE(1'b0)) dut_c (
        .clk_i(clk), .rst_i(rst), .in_valid_i(iv), .in_ready_o(c_ir),
        .in_ctrl_i(ictrl), .in_data_i(idata), .flush_i(flush),
        .out_valid_o(c_ov), .out_ready_i(ordy), .out_ctrl_o(c_oc),
        .out_data_o(c_od), .stall_cnt_o(c_cnt)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: the stage is a FIFO of depth 2 whose head is shown on the outputs.
    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            shown = '{8'h00, 128'h0};
            cnt   = 0;
        end else begin
            m_ov = (q.size() > 0);
            m_ir = (q.size() < 2);
            if (m_ov && !ordy) cnt++;
            if (flush) begin
                q.delete();
            end else begin
                if (m_ov && ordy) void'(q.pop_front());
                if (iv && m_ir) q.push_back('{ictrl, idata});
            end
            if (q.size() > 0) shown = q[0];
        end
    end

    always @(posedge clk) begin
        logic         ev, er;
        logic [15:0]  ecnt_a;
        logic [3:0]   ecnt_b;
        #2;
        if (chk_en) begin
            ev     = (q.size() > 0);
            er     = (q.size() < 2);
            ecnt_a = (cnt > 65535) ? 16'hFFFF : 16'(cnt);
            ecnt_b = (cnt > 15) ? 4'hF : 4'(cnt);
            chk("a_valid", a_ov, ev);
            chk("b_valid", b_ov, ev);
            chk("c_valid", c_ov, ev);
            chk("a_ready", a_ir, er);
            chk("b_ready", b_ir, er);
            chk("c_ready", c_ir, er);
            chk("a_cnt", a_cnt, ecnt_a);
            chk("b_cnt", b_cnt, ecnt_b);
            chk("c_cnt", c_cnt, ecnt_a);
            chk("a_ctrl", a_oc, ev ? shown.c : 8'h00);
            chk("b_ctrl", b_oc, ev ? shown.c : 8'h00);
            chk("c_ctrl", c_oc, shown.c);
            if (ev) begin
                chk("a_data", a_od, shown.d);
                chk("b_data", b_od, shown.d);
                chk("c_data", c_od, shown.d);
            end
        end
    end

    task automatic step(input bit r, input bit v, input logic [7:0] c,
                        input logic [127:0] d, input bit o, input bit f);
        @(negedge clk);
        rst = r; iv = v; ictrl = c; idata = d; ordy = o; flush = f;
        @(posedge clk);
        #3;
    endtask

    initial begin
        rst = 1'b1; iv = 1'b0; ictrl = '0; idata = '0; ordy = 1'b0; flush = 1'b0;

        // Reset with a beat presented: it must be ignored.
        step(1, 1, 8'hFF, 128'h1234, 1, 0);
        chk_en = 1'b1;
        step(1, 1, 8'hFF, 128'h1234, 1, 0);
        chk("rst_valid", a_ov, 1'b0);
        chk("rst_ctrl", a_oc, 8'h00);
        chk("rst_ready", a_ir, 1'b1);
        chk("rst_cnt", a_cnt, 16'd0);

        for (int unsigned k = 1; k <= 4; k++) begin
            step(0, 1, 8'(k), 128'(k), 1, 0);
            chk("stream_data", a_od, 128'(k));
            chk("stream_ready", a_ir, 1'b1);
            chk("stream_cnt", a_cnt, 16'd0);
        end
        step(0, 0, 8'h00, 128'h0, 1, 0);
        chk("stream_drain", a_ov, 1'b0);

        step(0, 1, 8'hA1, 128'h11, 0, 0);
        chk("bp_a_data", a_od, 128'h11);
        chk("bp_a_cnt", a_cnt, 16'd0);
        step(0, 1, 8'hB2, 128'h22, 0, 0);
        chk("bp_full_ready", a_ir, 1'b0);
        chk("bp_hold_data", a_od, 128'h11);
        chk("bp_b_cnt", a_cnt, 16'd1);
        step(0, 0, 8'h00, 128'h0, 0, 0);
        chk("bp_hold_cnt", a_cnt, 16'd2);
        step(0, 0, 8'h00, 128'h0, 1, 0);
        chk("bp_second_data", a_od, 128'h22);
        chk("bp_ready_back", a_ir, 1'b1);
        step(0, 0, 8'h00, 128'h0, 1, 0);
        chk("bp_empty", a_ov, 1'b0);

        step(0, 1, 8'hA1, 128'h11, 0, 0);
        step(0, 1, 8'hB2, 128'h22, 0, 0);
        step(0, 1, 8'hC3, 128'h99, 0, 1);
        chk("flush_valid", a_ov, 1'b0);
        chk("flush_ctrl", a_oc, 8'h00);
        chk("flush_ready", a_ir, 1'b1);
        chk("flush_cnt", a_cnt, 16'd4);
        step(0, 0, 8'h00, 128'h0, 1, 0);
        chk("flush_no_c", a_ov, 1'b0);

        step(0, 1, 8'h3C, 128'h77, 0, 0);
        for (int unsigned k = 0; k < 20; k++) step(0, 0, 8'h00, 128'h0, 0, 0);
        chk("sat_cnt4", b_cnt, 4'd15);
        chk("sat_cnt16", a_cnt, 16'd24);
        step(0, 0, 8'h00, 128'h0, 1, 0);

        step(0, 1, 8'h5A, 128'h55, 1, 0);
        step(0, 0, 8'h00, 128'h0, 1, 0);
        chk("nz_valid", c_ov, 1'b0);
        chk("nz_ctrl", c_oc, 8'h5A);
        chk("z_ctrl", a_oc, 8'h00);

        for (int unsigned k = 0; k < 1500; k++) begin
            step(($urandom_range(63) == 0),
                 ($urandom_range(2) != 0),
                 8'($urandom()),
                 {$urandom(), $urandom(), $urandom(), $urandom()},
                 ($urandom_range(3) != 0),
                 ($urandom_range(15) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
